// File: rtl/sync_rx_pkg.sv
// Shared constants for the synchronizer receive buffer.
package sync_rx_pkg;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 8;
    localparam int DROP_CW   = 16;
endpackage

// File: rtl/sync_rx_ram.sv
// Storage array for sync_rx_buffer: one write port, asynchronous read, no reset.
module sync_rx_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_rx_buffer.sv
// First-word-fall-through receive buffer behind a multi-bit synchronizer; drops on full, sticky ovf.
// Optional drop counter output enabled by defining SYNC_RXBUF_STAT_EN.
module sync_rx_buffer
    import sync_rx_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_vld,
    input  logic [DW-1:0]            din,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr
`ifdef SYNC_RXBUF_STAT_EN
    ,
    output logic [DROP_CW-1:0]       drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          ovf_q;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    assign out_vld = (level_q != '0);
    assign full    = (level_q == LVL_FULL);
    assign pop     = out_vld & out_rdy;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push    = in_vld & (~full | pop);
    assign drop    = in_vld & full & ~pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            // Drop outranks a concurrent clear so no overflow event is lost.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef SYNC_RXBUF_STAT_EN
    logic [DROP_CW-1:0] drop_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CW'(1);
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    sync_rx_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i (clk_i),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (dout)
    );

    assign level = level_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_sync_rx_buffer.sv
// Self-checking bench for sync_rx_buffer: directed vector table plus randomized run against a queue model.
module tb_sync_rx_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_vld;
    logic [DW-1:0] din;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] dout;
    logic [3:0]    level;
    logic          ovf;
    logic          ovf_clr;
`ifdef SYNC_RXBUF_STAT_EN
    logic [15:0]   drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    sync_rx_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_vld  (in_vld),
        .din     (din),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .dout    (dout),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`ifdef SYNC_RXBUF_STAT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] d;
        logic       rdy;
        logic       clr;
        logic       e_vld;
        logic [7:0] e_dout;
        int         e_lvl;
        logic       e_ovf;
        int         e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic vld, logic [7:0] d, logic rdy, logic clr,
                                logic e_vld, logic [7:0] e_dout, int e_lvl, logic e_ovf, int e_drop);
        vec_t v;
        v.rst = rst; v.vld = vld; v.d = d; v.rdy = rdy; v.clr = clr;
        v.e_vld = e_vld; v.e_dout = e_dout; v.e_lvl = e_lvl; v.e_ovf = e_ovf; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic rst, logic vld, logic [7:0] d, logic rdy, logic clr);
        rst_i   = rst;
        in_vld  = vld;
        din     = d;
        out_rdy = rdy;
        ovf_clr = clr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic compare(string tag, logic e_vld, logic [7:0] e_dout, int e_lvl, logic e_ovf, int e_drop);
        check({tag, ".out_vld"}, 32'(out_vld), 32'(e_vld));
        check({tag, ".level"}, 32'(level), 32'(e_lvl));
        check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
        if (e_vld) check({tag, ".dout"}, 32'(dout), 32'(e_dout));
`ifdef SYNC_RXBUF_STAT_EN
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(e_drop));
`endif
    endtask

    int          q[$];
    bit          m_ovf;
    int          m_drop;

    initial begin
        rst_i = 1'b1; in_vld = 1'b0; din = '0; out_rdy = 1'b0; ovf_clr = 1'b0;

        // reset, then single push held with out_rdy=0
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd4,  0, 0,  1, 8'd4,  1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,  1, 8'd4,  1, 0, 0));
        // ordering 4,5,10 with out_rdy=1
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd4,  1, 0,  1, 8'd4,  1, 0, 0));
        vecs.push_back(mk(0, 1, 8'd5,  1, 0,  1, 8'd5,  1, 0, 0));
        vecs.push_back(mk(0, 1, 8'd10, 1, 0,  1, 8'd10, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0));
        // fill 1..8 then drop 9
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 8'(i), 0, 0,  1, 8'd1, i, 0, 0));
        vecs.push_back(mk(0, 1, 8'd9,  0, 0,  1, 8'd1,  8, 1, 1));
        // clear racing a drop, then clear alone
        vecs.push_back(mk(0, 1, 8'h55, 0, 1,  1, 8'd1,  8, 1, 2));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 8'd1,  8, 0, 2));
        // full with simultaneous pop and push of AA, then drain
        vecs.push_back(mk(0, 1, 8'hAA, 1, 0,  1, 8'd2,  8, 0, 2));
        for (int i = 3; i <= 8; i++)
            vecs.push_back(mk(0, 0, 8'h00, 1, 0,  1, 8'(i), 10 - i, 0, 2));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  1, 8'hAA, 1, 0, 2));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 2));
        // reset at level 5 with in_vld/out_rdy asserted, then push 7
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0, 1, 8'(10 + i), 0, 0,  1, 8'd11, i, 0, 2));
        vecs.push_back(mk(1, 1, 8'h63, 1, 0,  0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd7,  0, 0,  1, 8'd7,  1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            compare($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_dout,
                    vecs[i].e_lvl, vecs[i].e_ovf, vecs[i].e_drop);
        end

        // randomized run against a queue model; starts from the empty state left above
        q.delete();
        m_ovf  = 0;
        m_drop = 0;
        for (int c = 0; c < 600; c++) begin
            logic       r_rst, r_vld, r_rdy, r_clr;
            logic [7:0] r_d;
            bit         popped;
            r_rst = ($urandom_range(0, 99) < 2);
            r_vld = ($urandom_range(0, 99) < 60);
            r_rdy = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 30 : 70));
            r_clr = ($urandom_range(0, 99) < 10);
            r_d   = 8'($urandom);
            if (r_rst) begin
                q.delete();
                m_ovf  = 0;
                m_drop = 0;
            end else begin
                popped = (q.size() > 0) && r_rdy;
                if (popped) void'(q.pop_front());
                if (r_vld && q.size() < DEPTH) begin
                    q.push_back(int'(r_d));
                    if (r_clr) m_ovf = 0;
                end else if (r_vld) begin
                    m_ovf = 1;
                    if (m_drop < 16'hFFFF) m_drop++;
                end else if (r_clr) begin
                    m_ovf = 0;
                end
            end
            drive(r_rst, r_vld, r_d, r_rdy, r_clr);
            compare($sformatf("rnd%0d", c), q.size() > 0, q.size() > 0 ? 8'(q[0]) : 8'h00,
                    q.size(), m_ovf, m_drop);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
